ita_requant_stage: RTL and testbench
====================================

ITA_REQUANT_STAGE -- requirements
Module: ita_requant_stage

Interface
REQ-001 SHALL have parameter N, default 16, number of parallel lanes.
REQ-002 SHALL have parameter WO, default 26, signed accumulator input width per lane.
REQ-003 SHALL have parameter WI, default 8, signed output width per lane.
REQ-004 SHALL have parameter EMS, default 8, width of multiplier and shift constants.
REQ-005 SHALL have parameter N_REQUANT_CONSTS, default 8, number of constant sets.
REQ-006 SHALL have one clock and a synchronous active-high reset: clk_i input 1 (rising edge) first, then rst_i input 1.
REQ-007 SHALL have port valid_i input 1, input beat valid.
REQ-008 SHALL have port ready_o output 1, stage accepts a beat.
REQ-009 SHALL have port data_i input N*WO, accumulator lanes (oup_t).
REQ-010 SHALL have port idx_i input clog2(N_REQUANT_CONSTS), constant-set select travelling with the beat.
REQ-011 SHALL have port eps_mult_i input N_REQUANT_CONSTS*EMS, unsigned multipliers.
REQ-012 SHALL have port right_shift_i input N_REQUANT_CONSTS*EMS, unsigned shift amounts.
REQ-013 SHALL have port add_i input N_REQUANT_CONSTS*WI, signed post-shift offsets.
REQ-014 SHALL have port valid_o output 1, output beat valid.
REQ-015 SHALL have port ready_i input 1, downstream accepts.
REQ-016 SHALL have port data_o output N*WI, requantized lanes (requant_oup_t).
REQ-017 SHALL have port busy_o output 1, high while any pipeline stage holds a beat.

Function
REQ-018 SHALL transfer a beat on input when valid_i & ready_o, and on output when valid_o & ready_i.
REQ-019 SHALL be a 3-stage pipeline: S1 = multiply, S2 = round and shift, S3 = add and saturate; latency 3 cycles from accept to valid_o.
REQ-020 SHALL let each stage advance when it is empty or the next stage advances; ready_o = S1 empty or S1 advancing (combinational from ready_i permitted).
REQ-021 SHALL sustain one beat per cycle with no bubbles while ready_i stays high.
REQ-022 SHALL sample eps_mult, right_shift and add for index idx_i at acceptance and carry them with the beat; later changes to the constant inputs do not affect in-flight beats.
REQ-023 S1 SHALL compute p = x * zero-extended mult as a signed WO+EMS+1-bit product, exact.
REQ-024 S2 SHALL compute r = (p + 2^(s-1)) >>> s arithmetically for s>0, and r = p for s=0.
REQ-025 S2 SHALL clamp s to WO+EMS; r is then 0 or -1 according to sign.
REQ-026 S3 SHALL compute q = r + sign-extended add at full width, then saturate to [-128, 127] for WI=8 (generally [-2^(WI-1), 2^(WI-1)-1]).
REQ-027 SHALL hold data_o and valid_o stable while valid_o & !ready_i.
REQ-028 SHALL process all N lanes identically with the same constant set.
REQ-029 SHALL assert busy_o from the first accept until the last beat leaves.

Reset
REQ-030 SHALL clear all stage valid bits on rst_i: valid_o=0, busy_o=0, data_o=0, ready_o=1 in the cycle after reset.
REQ-031 SHALL drop in-flight beats silently when rst_i asserts mid-operation, with no output beat produced for them.

Structure
REQ-032 SHALL place the constant RequantLatency=3 and type requant_idx_t in ita_package, reusing oup_t, requant_oup_t, requant_const_array_t and requant_array_t.
REQ-033 SHALL put per-lane arithmetic in sub-module ita_requant_lane, instantiated N times; the pipeline control stays in ita_requant_stage.

Verification
REQ-034 Nominal: x=100, mult=5, shift=3, add=-3 -> 60 on valid_o exactly 3 cycles after accept.
REQ-035 Rounding: x=4, mult=1, shift=3, add=0 -> 1; x=-4 -> 0; x=-1000, mult=3, shift=4, add=0 -> -128 (saturate low).
REQ-036 Saturation: x=1000, mult=3, shift=4, add=-10 -> 178, saturated to 127; shift=255 with x=-5 -> -1.
REQ-037 Backpressure: send 5 beats with ready_i low for 6 cycles -> ready_o falls after 3 accepts; all 5 beats emerge in order, none lost or duplicated.
REQ-038 Constant isolation: change idx_i and eps_mult_i one cycle after accept -> in-flight beat uses the original set; streaming 100 random beats with ready_i high gives 100 outputs back-to-back.
REQ-039 Reset: assert rst_i with 3 beats in flight -> next cycle valid_o=0, busy_o=0, and no stale beat appears afterwards.

Source files
------------

// File: rtl/ita_requant_stage_pkg.sv
// Shared constants and bus types for the requantization stage.
package ita_package;

  localparam int unsigned N                = 16;
  localparam int unsigned WO               = 26;
  localparam int unsigned WI               = 8;
  localparam int unsigned EMS              = 8;
  localparam int unsigned N_REQUANT_CONSTS = 8;

  // Pipeline depth from input accept to valid output.
  localparam int unsigned RequantLatency   = 3;

  typedef logic [N-1:0][WO-1:0]                oup_t;
  typedef logic [N-1:0][WI-1:0]                requant_oup_t;
  typedef logic [EMS-1:0]                      requant_const_t;
  typedef requant_const_t [N_REQUANT_CONSTS-1:0] requant_const_array_t;
  typedef logic [WI-1:0]                       requant_t;
  typedef requant_t [N_REQUANT_CONSTS-1:0]     requant_array_t;
  typedef logic [$clog2(N_REQUANT_CONSTS)-1:0] requant_idx_t;

endpackage

// File: rtl/ita_requant_lane.sv
// One requantization lane: multiply, round/shift, add/saturate, one register per step.
module ita_requant_lane #(
  parameter int unsigned WO  = 26,
  parameter int unsigned WI  = 8,
  parameter int unsigned EMS = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           ld_s1_i,
  input  logic           ld_s2_i,
  input  logic           ld_s3_i,
  input  logic [WO-1:0]  x_i,
  input  logic [EMS-1:0] mult_i,
  input  logic [EMS-1:0] shift_i,
  input  logic [WI-1:0]  add_i,
  output logic [WI-1:0]  q_o
);

  localparam int unsigned WP   = WO + EMS + 1;
  localparam int unsigned WS   = WP + 1;
  localparam int unsigned SMAX = WO + EMS;

  localparam logic signed [WS-1:0] QMAX = WS'((2 ** (WI - 1)) - 1);
  localparam logic signed [WS-1:0] QMIN = ~QMAX;

  logic signed [WP-1:0] w_x_ext;
  logic signed [WP-1:0] w_m_ext;
  logic signed [WP-1:0] w_prod;
  logic signed [WP-1:0] r_prod;
  logic        [EMS-1:0] w_sm1;
  logic signed [WP-1:0] w_sum;
  logic signed [WP-1:0] w_rnd;
  logic signed [WP-1:0] r_rnd;
  logic signed [WS-1:0] w_q;
  logic        [WI-1:0] w_sat;
  logic        [WI-1:0] r_q;

  // Exact signed product; the multiplier is treated as unsigned.
  assign w_x_ext = {{(EMS + 1){x_i[WO-1]}}, x_i};
  assign w_m_ext = {{(WO + 1){1'b0}}, mult_i};
  assign w_prod  = w_x_ext * w_m_ext;

  assign w_sm1   = shift_i - EMS'(1);

  // Round-half-up then arithmetic shift; oversized shifts collapse to the sign.
  always_comb begin
    w_sum = r_prod + (WP'(1) << w_sm1);
    w_rnd = r_prod;
    if (shift_i == '0) begin
      w_rnd = r_prod;
    end else if (32'(shift_i) >= SMAX) begin
      w_rnd = {WP{r_prod[WP-1]}};
    end else begin
      w_rnd = w_sum >>> shift_i;
    end
  end

  assign w_q = {r_rnd[WP-1], r_rnd} + {{(WS - WI){add_i[WI-1]}}, add_i};

  // Saturate the full-width sum into the signed output range.
  always_comb begin
    w_sat = w_q[WI-1:0];
    if (w_q > QMAX) begin
      w_sat = QMAX[WI-1:0];
    end else if (w_q < QMIN) begin
      w_sat = QMIN[WI-1:0];
    end
  end

  // Stage data registers, loaded only when a beat moves into the stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prod <= '0;
      r_rnd  <= '0;
      r_q    <= '0;
    end else begin
      if (ld_s1_i) r_prod <= w_prod;
      if (ld_s2_i) r_rnd  <= w_rnd;
      if (ld_s3_i) r_q    <= w_sat;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/ita_requant_stage.sv
// Three-stage requantization pipeline with valid/ready flow control over N lanes.
module ita_requant_stage #(
  parameter int unsigned N                = ita_package::N,
  parameter int unsigned WO               = ita_package::WO,
  parameter int unsigned WI               = ita_package::WI,
  parameter int unsigned EMS              = ita_package::EMS,
  parameter int unsigned N_REQUANT_CONSTS = ita_package::N_REQUANT_CONSTS
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [N*WO-1:0]                   data_i,
  input  logic [$clog2(N_REQUANT_CONSTS)-1:0] idx_i,
  input  logic [N_REQUANT_CONSTS*EMS-1:0]   eps_mult_i,
  input  logic [N_REQUANT_CONSTS*EMS-1:0]   right_shift_i,
  input  logic [N_REQUANT_CONSTS*WI-1:0]    add_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [N*WI-1:0]                   data_o,
  output logic                              busy_o
);

  logic           r_v1;
  logic           r_v2;
  logic           r_v3;
  logic [EMS-1:0] r_shift1;
  logic [WI-1:0]  r_add1;
  logic [WI-1:0]  r_add2;

  logic           w_en1;
  logic           w_en2;
  logic           w_en3;
  logic           w_ld1;
  logic           w_ld2;
  logic           w_ld3;
  logic [EMS-1:0] w_mult;
  logic [EMS-1:0] w_shift;
  logic [WI-1:0]  w_add;

  // A stage may take a new beat when it is empty or its content moves on.
  assign w_en3   = !r_v3 || ready_i;
  assign w_en2   = !r_v2 || w_en3;
  assign w_en1   = !r_v1 || w_en2;
  assign w_ld1   = w_en1 && valid_i;
  assign w_ld2   = w_en2 && r_v1;
  assign w_ld3   = w_en3 && r_v2;

  assign ready_o = w_en1;
  assign valid_o = r_v3;
  assign busy_o  = r_v1 || r_v2 || r_v3;

  // Select the constant set for the incoming beat.
  always_comb begin
    w_mult  = eps_mult_i   [int'(idx_i) * EMS +: EMS];
    w_shift = right_shift_i[int'(idx_i) * EMS +: EMS];
    w_add   = add_i        [int'(idx_i) * WI  +: WI];
  end

  // Stage valid bits and the constants that travel alongside each beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_shift1 <= '0;
      r_add1   <= '0;
      r_add2   <= '0;
    end else begin
      if (w_en1) r_v1 <= valid_i;
      if (w_en2) r_v2 <= r_v1;
      if (w_en3) r_v3 <= r_v2;
      if (w_ld1) begin
        r_shift1 <= w_shift;
        r_add1   <= w_add;
      end
      if (w_ld2) r_add2 <= r_add1;
    end
  end

  for (genvar g = 0; g < int'(N); g++) begin : g_lane
    ita_requant_lane #(
      .WO  (WO),
      .WI  (WI),
      .EMS (EMS)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .ld_s1_i (w_ld1),
      .ld_s2_i (w_ld2),
      .ld_s3_i (w_ld3),
      .x_i     (data_i[g*WO +: WO]),
      .mult_i  (w_mult),
      .shift_i (r_shift1),
      .add_i   (r_add2),
      .q_o     (data_o[g*WI +: WI])
    );
  end

endmodule

// File: tb/tb_ita_requant_stage.sv
// Scoreboard bench for ita_requant_stage: expected beats queued at accept, checked at output.
module tb_ita_requant_stage;
  import ita_package::*;

  localparam int unsigned NC = N_REQUANT_CONSTS;
  localparam int unsigned QW = N * WI;
  localparam int unsigned DW = N * WO;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic             ready_o;
  logic [DW-1:0]    data_i;
  requant_idx_t     idx_i;
  logic [NC*EMS-1:0] eps_mult_i;
  logic [NC*EMS-1:0] right_shift_i;
  logic [NC*WI-1:0]  add_i;
  logic             valid_o;
  logic             ready_i;
  logic [QW-1:0]    data_o;
  logic             busy_o;

  logic [EMS-1:0] t_mult  [NC];
  logic [EMS-1:0] t_shift [NC];
  logic [WI-1:0]  t_add   [NC];

  for (genvar g = 0; g < int'(NC); g++) begin : g_const
    assign eps_mult_i   [g*EMS +: EMS] = t_mult[g];
    assign right_shift_i[g*EMS +: EMS] = t_shift[g];
    assign add_i        [g*WI  +: WI]  = t_add[g];
  end

  ita_requant_stage dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .data_i        (data_i),
    .idx_i         (idx_i),
    .eps_mult_i    (eps_mult_i),
    .right_shift_i (right_shift_i),
    .add_i         (add_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .data_o        (data_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [QW-1:0] exp;
    int            acc_cyc;
    bit            chk_lat;
  } sb_t;

  sb_t sb[$];
  int  out_cyc_q[$];
  int  n_tot = 0;
  int  n_bad = 0;
  int  n_out = 0;
  int  cyc   = 0;
  bit  rb_on = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference arithmetic for one lane, done in 64-bit integers.
  function automatic logic [WI-1:0] model_lane(input longint x, input int m, input int s, input int a);
    longint p;
    longint r;
    longint q;
    longint qmax;
    p    = x * longint'(m);
    qmax = (longint'(1) <<< (WI - 1)) - 1;
    if (s == 0)                 r = p;
    else if (s >= int'(WO + EMS)) r = (p < 0) ? -1 : 0;
    else                        r = (p + (longint'(1) <<< (s - 1))) >>> s;
    q = r + longint'(a);
    if (q > qmax)          q = qmax;
    else if (q < -qmax - 1) q = -qmax - 1;
    return WI'(q);
  endfunction

  function automatic logic [QW-1:0] model_vec(input logic [DW-1:0] d, input logic [EMS-1:0] m,
                                               input logic [EMS-1:0] s, input logic [WI-1:0] a);
    logic [QW-1:0] v;
    logic [WO-1:0] x;
    v = '0;
    for (int i = 0; i < int'(N); i++) begin
      x = d[i*WO +: WO];
      v[i*WI +: WI] = model_lane(longint'($signed(x)), int'(m), int'(s), int'($signed(a)));
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] rep_x(input int x);
    logic [DW-1:0] d;
    for (int i = 0; i < int'(N); i++) d[i*WO +: WO] = WO'(x);
    return d;
  endfunction

  function automatic logic [QW-1:0] rep_q(input int v);
    logic [QW-1:0] q;
    for (int i = 0; i < int'(N); i++) q[i*WI +: WI] = WI'(v);
    return q;
  endfunction

  function automatic logic [DW-1:0] rand_x();
    logic [DW-1:0] d;
    for (int i = 0; i < int'(N); i++) d[i*WO +: WO] = WO'($urandom);
    return d;
  endfunction

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic set_const(input int k, input int m, input int s, input int a);
    t_mult[k]  = EMS'(m);
    t_shift[k] = EMS'(s);
    t_add[k]   = WI'(a);
  endtask

  // Offer one beat, wait (bounded) for acceptance, queue its expected result.
  task automatic send(input logic [DW-1:0] d, input int idx, input bit use_exp,
                      input logic [QW-1:0] exp, input bit lat);
    sb_t e;
    int  w;
    data_i  = d;
    idx_i   = requant_idx_t'(idx);
    valid_i = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!ready_o && w < 100);
    if (!ready_o) chk("accept_timeout", QW'(ready_o), QW'(1));
    e.exp     = use_exp ? exp : model_vec(d, t_mult[idx], t_shift[idx], t_add[idx]);
    e.acc_cyc = cyc;
    e.chk_lat = lat;
    if (ready_o) sb.push_back(e);
    align();
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain", QW'(sb.size()), QW'(0));
    align();
  endtask

  // Output monitor: hold-stability under stall, in-order data, latency tag.
  initial begin : mon
    logic          prev_stall;
    logic [QW-1:0] prev_data;
    sb_t           e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_valid", QW'(valid_o), QW'(1));
        chk("hold_data", data_o, prev_data);
      end
      if (!rst_i && valid_o && ready_i) begin
        n_out++;
        out_cyc_q.push_back(cyc);
        chk("sb_nonempty", QW'(sb.size() != 0), QW'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("data", data_o, e.exp);
          if (e.chk_lat) chk("latency", QW'(cyc - e.acc_cyc), QW'(RequantLatency));
        end
      end
      prev_stall = valid_o && !ready_i && !rst_i;
      prev_data  = data_o;
    end
  end

  // Random downstream backpressure while enabled.
  initial begin : rnd_ready
    forever begin
      @(posedge clk);
      #1;
      if (rb_on) ready_i = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int n0;
    int st;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i  = '0;
    idx_i   = '0;
    for (int k = 0; k < int'(NC); k++) set_const(k, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", QW'(valid_o), QW'(0));
    chk("rst_busy",  QW'(busy_o),  QW'(0));
    chk("rst_data",  data_o,       QW'(0));
    chk("rst_ready", QW'(ready_o), QW'(1));
    align();

    // Nominal beat with latency check.
    set_const(0, 5, 3, -3);
    send(rep_x(100), 0, 1, rep_q(60), 1);
    @(negedge clk);
    chk("busy_inflight", QW'(busy_o), QW'(1));
    drain();
    @(negedge clk);
    chk("busy_idle", QW'(busy_o), QW'(0));
    align();

    // Rounding, shift-zero, saturation and oversized shift corner cases.
    set_const(1, 1, 3, 0);
    set_const(2, 3, 4, 0);
    set_const(3, 3, 4, -10);
    set_const(4, 3, 255, 0);
    set_const(5, 2, 0, 1);
    send(rep_x(4),     1, 1, rep_q(1),    0);
    send(rep_x(-4),    1, 1, rep_q(0),    0);
    send(rep_x(-1000), 2, 1, rep_q(-128), 0);
    send(rep_x(1000),  3, 1, rep_q(127),  0);
    send(rep_x(-5),    4, 1, rep_q(-1),   0);
    send(rep_x(50),    5, 1, rep_q(101),  0);
    send(rep_x(-60),   5, 1, rep_q(-119), 0);
    drain();

    // Backpressure: 5 beats, ready_i low for 6 cycles.
    n0 = n_out;
    ready_i = 1'b0;
    fork
      begin
        repeat (6) @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join_none
    for (int k = 0; k < 3; k++) send(rep_x(10 * k + 7), 0, 0, '0, 0);
    @(negedge clk);
    chk("bp_ready_low", QW'(ready_o), QW'(0));
    align();
    for (int k = 3; k < 5; k++) send(rep_x(10 * k + 7), 0, 0, '0, 0);
    drain();
    chk("bp_count", QW'(n_out - n0), QW'(5));

    // Constants change right after accept; the in-flight beat keeps its set.
    set_const(2, 7, 2, 5);
    set_const(5, 11, 1, -2);
    send(rand_x(), 2, 0, '0, 0);
    idx_i = requant_idx_t'(5);
    set_const(2, 200, 0, 0);
    data_i = rand_x();
    align();
    send(rand_x(), 2, 0, '0, 0);
    send(rand_x(), 5, 0, '0, 0);
    drain();

    // 100 random beats streamed with ready_i high.
    for (int k = 0; k < int'(NC); k++)
      set_const(k, int'($urandom_range(0, 255)), int'($urandom_range(0, 40)), int'($urandom_range(0, 255)));
    out_cyc_q.delete();
    st = cyc;
    for (int k = 0; k < 100; k++) send(rand_x(), int'($urandom_range(0, NC - 1)), 0, '0, 0);
    chk("stream_in_cycles", QW'(cyc - st), QW'(100));
    drain();
    chk("stream_out_count", QW'(out_cyc_q.size()), QW'(100));
    if (out_cyc_q.size() == 100) chk("stream_out_span", QW'(out_cyc_q[99] - out_cyc_q[0]), QW'(99));

    // Random backpressure.
    rb_on = 1'b1;
    for (int k = 0; k < 40; k++) send(rand_x(), int'($urandom_range(0, NC - 1)), 0, '0, 0);
    rb_on = 1'b0;
    align();
    ready_i = 1'b1;
    drain();

    // Reset with three beats in flight.
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) send(rand_x(), 0, 0, '0, 0);
    @(negedge clk);
    chk("full_busy",  QW'(busy_o),  QW'(1));
    chk("full_valid", QW'(valid_o), QW'(1));
    align();
    rst_i = 1'b1;
    sb.delete();
    align();
    @(negedge clk);
    chk("midrst_valid", QW'(valid_o), QW'(0));
    chk("midrst_busy",  QW'(busy_o),  QW'(0));
    align();
    rst_i   = 1'b0;
    ready_i = 1'b1;
    n0 = n_out;
    repeat (8) @(negedge clk);
    chk("post_rst_no_out", QW'(n_out - n0), QW'(0));
    chk("post_rst_data", data_o, QW'(0));
    align();
    set_const(0, 5, 3, -3);
    send(rep_x(100), 0, 1, rep_q(60), 1);
    drain();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
